// File: rtl/data_memory_controller_if.sv
// Data-memory-stage bundle: pipeline command/response plus the
// word-wide backing-memory request/ack bus.
interface data_memory_controller_if;
  logic [31:0] ALU_OUT_IN;
  logic [2:0]  DATA_CACHE_LOAD_IN;
  logic [1:0]  DATA_CACHE_STORE_IN;
  logic [31:0] DATA_CACHE_STORE_DATA_IN;
  logic        STALL_DATA_MEMORY_STAGE;
  logic [31:0] DATA_OUT;
  logic        MISALIGNED;
  logic        BUS_ERROR;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [29:0] MEM_ADDR;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;

  modport slave (
    input  ALU_OUT_IN,
    input  DATA_CACHE_LOAD_IN,
    input  DATA_CACHE_STORE_IN,
    input  DATA_CACHE_STORE_DATA_IN,
    output STALL_DATA_MEMORY_STAGE,
    output DATA_OUT,
    output MISALIGNED,
    output BUS_ERROR,
    output MEM_REQ,
    output MEM_WE,
    output MEM_ADDR,
    output MEM_BYTE_EN,
    output MEM_WDATA,
    input  MEM_ACK,
    input  MEM_RDATA
  );

  modport master (
    output ALU_OUT_IN,
    output DATA_CACHE_LOAD_IN,
    output DATA_CACHE_STORE_IN,
    output DATA_CACHE_STORE_DATA_IN,
    input  STALL_DATA_MEMORY_STAGE,
    input  DATA_OUT,
    input  MISALIGNED,
    input  BUS_ERROR,
    input  MEM_REQ,
    input  MEM_WE,
    input  MEM_ADDR,
    input  MEM_BYTE_EN,
    input  MEM_WDATA,
    output MEM_ACK,
    output MEM_RDATA
  );
endinterface

// File: rtl/data_memory_controller.sv
// Data-memory-stage responder: one backing-memory transaction per
// command, store lane steering, load extension, stall generation.
module data_memory_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic CLK,
  input logic RST_N,
  data_memory_controller_if.slave bus
);

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [2:0]  ld;
  logic [1:0]  st;
  logic [1:0]  off;
  logic        is_st, is_ld;
  logic        half, word, mis, go;
  logic        issue, ack_hit, tmo, mis_evt;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] shifted, ext;

  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] dout;
  logic        misaligned, bus_error;
  logic [7:0]  cnt;
  logic [2:0]  ld_op;
  logic [1:0]  ld_off;

  assign ld  = bus.DATA_CACHE_LOAD_IN;
  assign st  = bus.DATA_CACHE_STORE_IN;
  assign off = bus.ALU_OUT_IN[1:0];

  always_comb begin
    is_st = st != 2'd0;
    is_ld = !is_st && ld != 3'd0 && ld <= 3'd5;
    half  = st == 2'd2 ||
            (is_ld && (ld == 3'd2 || ld == 3'd5));
    word  = st == 2'd3 || (is_ld && ld == 3'd3);
    mis   = (half && off[0]) ||
            (word && off != 2'd0);
    go    = (is_st || is_ld) && !mis;
  end

  always_comb begin
    be_n = 4'b0000;
    wd_n = 32'd0;
    unique case (1'b1)
      st == 2'd1: begin
        be_n = 4'b0001 << off;
        wd_n = {4{bus.DATA_CACHE_STORE_DATA_IN[7:0]}};
      end
      st == 2'd2: begin
        be_n = 4'b0011 << off;
        wd_n = {2{bus.DATA_CACHE_STORE_DATA_IN[15:0]}};
      end
      st == 2'd3: begin
        be_n = 4'b1111;
        wd_n = bus.DATA_CACHE_STORE_DATA_IN;
      end
      default: begin
        be_n = 4'b0000;
        wd_n = 32'd0;
      end
    endcase
  end

  always_comb begin
    shifted = bus.MEM_RDATA >> {ld_off, 3'b000};
    ext     = bus.MEM_RDATA;
    unique case (1'b1)
      ld_op == 3'd1: ext = {{24{shifted[7]}}, shifted[7:0]};
      ld_op == 3'd2: ext = {{16{shifted[15]}}, shifted[15:0]};
      ld_op == 3'd4: ext = {24'd0, shifted[7:0]};
      ld_op == 3'd5: ext = {16'd0, shifted[15:0]};
      default:       ext = bus.MEM_RDATA;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    issue   = LOW;
    ack_hit = LOW;
    tmo     = LOW;
    mis_evt = LOW;
    unique case (state)
      IDLE: begin
        mis_evt = (is_st || is_ld) && mis;
        if (go) begin
          issue   = HIGH;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.MEM_ACK) begin
          ack_hit = HIGH;
          state_n = DONE;
        end else if (cnt == TO_LAST) begin
          tmo     = HIGH;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Gated by reset so a command held during reset never stalls.
  assign bus.STALL_DATA_MEMORY_STAGE =
    RST_N && ((state == IDLE && go) || state == WAIT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_req    <= LOW;
      mem_we     <= LOW;
      mem_addr   <= 30'd0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
      dout       <= 32'd0;
      misaligned <= LOW;
      bus_error  <= LOW;
      cnt        <= 8'd0;
      ld_op      <= 3'd0;
      ld_off     <= 2'd0;
    end else begin
      misaligned <= mis_evt;
      bus_error  <= tmo;
      if (issue) begin
        mem_req   <= HIGH;
        mem_we    <= is_st;
        mem_addr  <= bus.ALU_OUT_IN[31:2];
        mem_be    <= be_n;
        mem_wdata <= wd_n;
        cnt       <= 8'd0;
        ld_op     <= is_ld ? ld : 3'd0;
        ld_off    <= off;
      end else if (state == WAIT) begin
        cnt <= cnt + 8'd1;
        if (ack_hit || tmo) mem_req <= LOW;
        if (ack_hit && ld_op != 3'd0) dout <= ext;
      end
    end
  end

  assign bus.MEM_REQ     = mem_req;
  assign bus.MEM_WE      = mem_we;
  assign bus.MEM_ADDR    = mem_addr;
  assign bus.MEM_BYTE_EN = mem_be;
  assign bus.MEM_WDATA   = mem_wdata;
  assign bus.DATA_OUT    = dout;
  assign bus.MISALIGNED  = misaligned;
  assign bus.BUS_ERROR   = bus_error;

endmodule

// File: doc/data_memory_controller.md
# data_memory_controller

- Responder side of the data-memory-stage interface.
- Consumes the registered load/store command, address, store data and write-back controls held by the data-memory-stage pipeline register.
- Runs one transaction per command on a variable-latency word-wide backing memory: store byte-lane steering, load sign/zero extension.
- Drives `STALL_DATA_MEMORY_STAGE` so the pipeline register holds its command until the access completes.

## Interface
- `HIGH`, 1'b1, logic-true level
- `LOW`, 1'b0, logic-false level
- `TIMEOUT_CYCLES`, 255, max cycles in WAIT before abort; range 1..255
- `CLK` in 1: sole clock, rising edge
- `RST_N` in 1: reset, asynchronous, active-low
- `ALU_OUT_IN` in 32: byte address of the access
- `DATA_CACHE_LOAD_IN` in 3: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6/7 treated as none
- `DATA_CACHE_STORE_IN` in 2: 0 none, 1 SB, 2 SH, 3 SW
- `DATA_CACHE_STORE_DATA_IN` in 32: rs2 value, low-aligned
- `STALL_DATA_MEMORY_STAGE` out 1: holds the upstream pipeline register
- `DATA_OUT` out 32: registered, extended load result
- `MISALIGNED` out 1: one-cycle pulse
- `BUS_ERROR` out 1: one-cycle pulse
- `MEM_REQ` out 1: request to the backing memory
- `MEM_WE` out 1: request is a write
- `MEM_ADDR` out 30: word address, `ALU_OUT_IN[31:2]`
- `MEM_BYTE_EN` out 4: write lane enables
- `MEM_WDATA` out 32: lane-steered write data
- `MEM_ACK` in 1: one-cycle completion from memory
- `MEM_RDATA` in 32: read word, valid with `MEM_ACK`

## Operation
- States: IDLE, WAIT, DONE.
- Command present = store != 0 or load in 1..5. Store has priority if both are nonzero; the load is ignored.
- Alignment check in IDLE:
  - Halfword ops: misaligned if `addr[0]`.
  - Word ops: misaligned if `addr[1:0] != 0`.
  - Misaligned command: `MISALIGNED` pulses next cycle, no `MEM_REQ`, no stall, `DATA_OUT` unchanged, stay IDLE.
- IDLE, aligned command:
  - Stall combinationally high.
  - Register `MEM_REQ`=1, `MEM_WE`, `MEM_ADDR`, `MEM_BYTE_EN`, `MEM_WDATA`.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - Stall high; `MEM_REQ` and request fields held stable.
  - Counter increments each cycle.
  - `MEM_ACK`: drop `MEM_REQ`. For a load, latch the extended result into `DATA_OUT`. Go to DONE.
  - Counter reaches `TIMEOUT_CYCLES` without ack: drop `MEM_REQ`, pulse `BUS_ERROR`, `DATA_OUT` unchanged, go to DONE.
- DONE: stall low for exactly one cycle so the pipeline advances. Inputs are ignored (same command still present). Go to IDLE.
- Store steering:
  - SB: byte replicated on all four lanes; enable `1 << addr[1:0]`.
  - SH: halfword replicated on both halves; enable `4'b0011 << addr[1:0]`.
  - SW: data as-is; enable `4'b1111`.
  - Loads drive `MEM_BYTE_EN` = 0.
- Load extraction: select the byte/half by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `MEM_ACK` outside WAIT is ignored.

## Timing
- Reset (async assert, sync-safe release) sets:
  - state IDLE
  - `MEM_REQ`, `MEM_WE`, `MISALIGNED`, `BUS_ERROR` = 0
  - `MEM_ADDR`, `MEM_BYTE_EN`, `MEM_WDATA`, `DATA_OUT`, counter = 0
  - `STALL_DATA_MEMORY_STAGE` = 0 (state IDLE, no command evaluated during reset)
- Reset mid-WAIT aborts the transaction: `MEM_REQ` drops immediately; no error pulse.
- Latency, command visible in IDLE at cycle 0:
  - `MEM_REQ` high from cycle 1.
  - Ack at cycle k: `DATA_OUT` valid and stall low at cycle k+1.
  - Back-to-back commands: minimum 3 cycles per access (ack on cycle 1).
- Stall is high from cycle 0 through the ack cycle inclusive.
- `MISALIGNED` and `BUS_ERROR` are registered, high for one cycle only.

## Test plan
- Reset with command present: `RST_N`=0 while LW addr 0x10 is driven → all outputs 0, no `MEM_REQ`. Release → `MEM_REQ`=1, `MEM_ADDR`=0x4 one cycle later.
- Load extension at addr 0x103:
  - `MEM_RDATA`=0x80FF7F01 returned after a 2-cycle ack delay.
  - LB → `DATA_OUT`=0xFFFFFF80; LBU → 0x00000080.
  - LH at 0x102 → 0xFFFF80FF.
  - Stall high for exactly 3 cycles.
- Store steering:
  - SB data 0xAB at 0x101 → `MEM_BYTE_EN`=4'b0010, `MEM_WDATA`=0xABABABAB, `MEM_WE`=1.
  - SH 0x1234 at 0x102 → 4'b1100, 0x12341234.
- Misaligned: LW at 0x102 → `MISALIGNED`=1 for one cycle, no `MEM_REQ`, stall never asserted, `DATA_OUT` unchanged.
- Timeout: `TIMEOUT_CYCLES`=4, SW with no ack → `BUS_ERROR` pulses after 4 WAIT cycles, `MEM_REQ` drops, then one DONE cycle with stall low.
- Priority and spurious ack: store=SW with load=LW at the same time → `MEM_WE`=1, `DATA_OUT` unchanged; `MEM_ACK` pulsed in IDLE → no state change.
